temp_frame_latch: RTL and testbench
===================================

// Module: temp_frame_latch
// PURPOSE
//  Upstream feeder of the VGA driver's temperatura/dig_temp inputs. Accepts raw 8-bit
//  temperature samples (deg C) over valid/ready, averages 2^AVG_LOG2 samples and maps the
//  average to a 4-bit bar level plus 4 status flags. Outputs change only at the start of
//  the vsync pulse, so the bar never tears mid-frame. Same clock domain as the VGA driver.
// PARAMETERS
//  AVG_LOG2        3      log2 of samples per average (1..6)
//  T_MIN           8'd16  temperature mapped to level 0
//  T_STEP_LOG2     1      level step = 2^T_STEP_LOG2 deg C
//  T_HIGH          8'd40  avg >= T_HIGH raises HIGH flag
//  TIMEOUT_FRAMES  60     frames without an accepted sample before TIMEOUT flag (1..255)
//  VSYNC_ACT_LOW   1      1: ivsync pulse is active-low
// PORTS
//  iclock          in   1  pixel clock, same as VGA driver
//  ireset_n        in   1  async active-low reset
//  isample         in   8  raw temperature, unsigned deg C
//  isample_valid   in   1  isample valid this cycle
//  osample_ready   out  1  block accepts isample this cycle
//  ivsync          in   1  vsync from the vertical sync stage
//  otemperatura    out  4  bar level 0..15 -> driver temperatura
//  odig_temp       out  4  [1]=LOW [2]=NORMAL [3]=HIGH [4]=TIMEOUT -> driver dig_temp
//  oframe_update   out  1  1-cycle pulse when outputs were reloaded
// BEHAVIOUR
//  Reset (async assert, sync release): otemperatura=0, odig_temp=0, oframe_update=0,
//   acc=0, cnt=0, pending_valid=0, frame_cnt=0, state=ACCUM, vsync history = inactive level.
//  FSM: ACCUM -> COMMIT when the 2^AVG_LOG2-th sample is accepted; COMMIT -> ACCUM always (1 cycle).
//  Handshake: transfer when isample_valid & osample_ready. osample_ready=1 in ACCUM, 0 in COMMIT.
//   isample must be held while valid & !ready.
//  ACCUM: acc (8+AVG_LOG2 bits, no overflow possible) += isample; cnt++.
//  COMMIT: avg = acc >> AVG_LOG2 (truncate); pending_lvl, pending_flags computed; pending_valid=1;
//   acc, cnt cleared. Newer pending overwrites an unconsumed one (only latest kept).
//  Level: avg < T_MIN -> 0; else min(15, (avg-T_MIN) >> T_STEP_LOG2).
//  Flags: LOW = avg<T_MIN; HIGH = avg>=T_HIGH; NORMAL = !LOW & !HIGH; TIMEOUT from frame_cnt.
//  Frame edge: one cycle when ivsync goes inactive->active (registered edge detect, no sync FFs).
//   If pending_valid: next cycle otemperatura/odig_temp[3:1] = pending, pending_valid=0, oframe_update=1.
//   If not: outputs hold, oframe_update=0.
//  Same-cycle COMMIT and frame edge: edge uses pending state before this COMMIT; new value shown next frame.
//  Timeout: frame_cnt counts frame edges, saturates at TIMEOUT_FRAMES, clears on any accepted sample.
//   odig_temp[4] = (frame_cnt == TIMEOUT_FRAMES), updated on frame edges only. When set,
//   otemperatura and odig_temp[3:1] hold last values. oframe_update pulses whenever [4] changes.
//  Same-cycle sample accept and frame edge: frame_cnt clears (accept wins).
//  Reset mid-average: partial accumulation discarded, no output until a full block commits.
// TESTING
//  1 Reset, 8 samples of 8'd30, then vsync pulse -> otemperatura=7, odig_temp=4'b0010, one oframe_update.
//  2 8 samples 8'd10 -> level 0, odig_temp=4'b0001; 8 samples 8'd200 -> level 15, odig_temp=4'b0100.
//  3 Samples 29,30 x4 alternating (avg 29) -> level 6; outputs unchanged until the vsync edge.
//  4 isample_valid held high continuously -> ready drops exactly 1 cycle per 8 accepts; no sample lost/duplicated.
//  5 COMMIT coincident with vsync edge -> old value kept this frame, new value loaded at next edge.
//  6 Stop samples, 60 vsync pulses -> odig_temp[4]=1 after 60th edge; one new sample clears it at next edge.

Source files
------------

// File: rtl/temp_frame_latch_if.sv
// Sample stream handshake between the temperature source and temp_frame_latch.
// The source drives the sample and valid; the latch drives ready.
interface temp_frame_latch_if;
  logic [7:0] isample;
  logic       isample_valid;
  logic       osample_ready;

  modport master (
    output isample,
    output isample_valid,
    input  osample_ready
  );

  modport slave (
    input  isample,
    input  isample_valid,
    output osample_ready
  );
endinterface

// File: rtl/temp_frame_latch.sv
// Averages blocks of temperature samples and presents a bar level plus status flags to the
// VGA driver, reloading the visible values only at the start of a vsync pulse.
module temp_frame_latch #(
  parameter int          AVG_LOG2       = 3,
  parameter logic [7:0]  T_MIN          = 8'd16,
  parameter int          T_STEP_LOG2    = 1,
  parameter logic [7:0]  T_HIGH         = 8'd40,
  parameter int          TIMEOUT_FRAMES = 60,
  parameter int          VSYNC_ACT_LOW  = 1
) (
  input  logic                iclock,
  input  logic                ireset_n,
  temp_frame_latch_if.slave   sif,
  input  logic                ivsync,
  output logic [3:0]          otemperatura,
  output logic [3:0]          odig_temp,
  output logic                oframe_update
);

  localparam int         ACC_W  = 8 + AVG_LOG2;
  localparam int         CNT_W  = AVG_LOG2;
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_FRAMES);

  typedef enum logic [0:0] {ACCUM = 1'b0, COMMIT = 1'b1} state_t;

  logic [1:0]       rst_sync_r;
  logic             rst_int_n_s;
  state_t           state_r;
  logic [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic             ready_r;
  logic             pend_valid_r;
  logic [3:0]       pend_lvl_r;
  logic [2:0]       pend_flg_r;
  logic [7:0]       frame_cnt_r;
  logic             vsync_prev_r;
  logic [3:0]       lvl_r;
  logic [2:0]       flg_r;
  logic             timeout_r;
  logic             update_r;

  logic             vsync_act_s;
  logic             edge_s;
  logic             accept_s;
  logic [7:0]       avg_s;
  logic [7:0]       frame_nxt_s;
  logic             timeout_nxt_s;

  function automatic logic [3:0] level_of(input logic [7:0] avg);
    logic [7:0] d;
    if (avg < T_MIN) begin
      level_of = 4'd0;
    end else begin
      d = (avg - T_MIN) >> T_STEP_LOG2;
      level_of = (d > 8'd15) ? 4'd15 : d[3:0];
    end
  endfunction

  // {HIGH, NORMAL, LOW}
  function automatic logic [2:0] flags_of(input logic [7:0] avg);
    logic lo;
    logic hi;
    lo = (avg < T_MIN);
    hi = (avg >= T_HIGH);
    flags_of = {hi, ~lo & ~hi, lo};
  endfunction

  assign vsync_act_s   = (VSYNC_ACT_LOW != 0) ? ~ivsync : ivsync;
  assign edge_s        = vsync_act_s & ~vsync_prev_r;
  assign accept_s      = sif.isample_valid & ready_r;
  assign avg_s         = acc_r[ACC_W-1 -: 8];
  assign timeout_nxt_s = (frame_nxt_s == TO_LIM);
  assign rst_int_n_s   = rst_sync_r[1];

  // Frame counter: accepted samples clear it, frame edges advance it up to the limit.
  always_comb begin
    frame_nxt_s = frame_cnt_r;
    if (accept_s) begin
      frame_nxt_s = 8'd0;
    end else if (edge_s && (frame_cnt_r < TO_LIM)) begin
      frame_nxt_s = frame_cnt_r + 8'd1;
    end else begin
      frame_nxt_s = frame_cnt_r;
    end
  end

  // Reset synchronizer: asynchronous assertion, release aligned to the clock.
  always_ff @(posedge iclock or negedge ireset_n) begin
    if (!ireset_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  // Accumulate/commit FSM together with the frame-synchronous output registers.
  always_ff @(posedge iclock or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      state_r      <= ACCUM;
      acc_r        <= {ACC_W{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      ready_r      <= 1'b1;
      pend_valid_r <= 1'b0;
      pend_lvl_r   <= 4'd0;
      pend_flg_r   <= 3'd0;
      frame_cnt_r  <= 8'd0;
      vsync_prev_r <= 1'b0;
      lvl_r        <= 4'd0;
      flg_r        <= 3'd0;
      timeout_r    <= 1'b0;
      update_r     <= 1'b0;
    end else begin
      update_r     <= 1'b0;
      vsync_prev_r <= vsync_act_s;
      frame_cnt_r  <= frame_nxt_s;
      // The edge consumes the pending value as it stood before any same-cycle commit.
      if (edge_s) begin
        timeout_r <= timeout_nxt_s;
        if (pend_valid_r && !timeout_nxt_s) begin
          lvl_r        <= pend_lvl_r;
          flg_r        <= pend_flg_r;
          pend_valid_r <= 1'b0;
          update_r     <= 1'b1;
        end
        if (timeout_nxt_s != timeout_r) begin
          update_r <= 1'b1;
        end
      end
      case (state_r)
        ACCUM: begin
          if (accept_s) begin
            acc_r <= acc_r + ACC_W'(sif.isample);
            cnt_r <= cnt_r + CNT_W'(1);
            if (cnt_r == {CNT_W{1'b1}}) begin
              state_r <= COMMIT;
              ready_r <= 1'b0;
            end
          end
        end
        COMMIT: begin
          pend_lvl_r   <= level_of(avg_s);
          pend_flg_r   <= flags_of(avg_s);
          pend_valid_r <= 1'b1;
          acc_r        <= {ACC_W{1'b0}};
          cnt_r        <= {CNT_W{1'b0}};
          state_r      <= ACCUM;
          ready_r      <= 1'b1;
        end
        default: begin
          state_r <= ACCUM;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign sif.osample_ready = ready_r;
  assign otemperatura      = lvl_r;
  assign odig_temp         = {timeout_r, flg_r};
  assign oframe_update     = update_r;

endmodule

// File: tb/tb_temp_frame_latch.sv
// Bench for temp_frame_latch: table of averaged blocks, hand-written corner sequences and
// a randomized run, all compared cycle by cycle against a queue-based reference model.
module tb_temp_frame_latch;

  logic       iclock;
  logic       ireset_n;
  logic       ivsync;
  logic [3:0] otemperatura;
  logic [3:0] odig_temp;
  logic       oframe_update;

  temp_frame_latch_if tif ();

  temp_frame_latch dut (
    .iclock        (iclock),
    .ireset_n      (ireset_n),
    .sif           (tif.slave),
    .ivsync        (ivsync),
    .otemperatura  (otemperatura),
    .odig_temp     (odig_temp),
    .oframe_update (oframe_update)
  );

  initial iclock = 1'b0;
  always #5 iclock = ~iclock;

  int checks = 0;
  int fails  = 0;

  // reference model state
  int         m_q[$];
  bit         m_busy;
  bit         m_vs_act;
  bit         m_pv;
  logic [3:0] m_pl;
  logic [2:0] m_pf;
  logic [3:0] m_lvl;
  logic [2:0] m_flg;
  bit         m_to;
  int         m_fc;
  bit         m_upd;

  function automatic logic [3:0] ref_level(input int avg);
    int d;
    if (avg < 16) return 4'd0;
    d = (avg - 16) / 2;
    return (d > 15) ? 4'd15 : 4'(d);
  endfunction

  function automatic logic [2:0] ref_flags(input int avg);
    if (avg < 16) return 3'b001;
    if (avg >= 40) return 3'b100;
    return 3'b010;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_busy = 1'b0; m_vs_act = 1'b0; m_pv = 1'b0; m_pl = 4'd0; m_pf = 3'd0;
    m_lvl = 4'd0; m_flg = 3'd0; m_to = 1'b0; m_fc = 0; m_upd = 1'b0;
  endtask

  task automatic model_update(input logic v, input logic [7:0] s, input logic vs);
    bit acc;
    bit edg;
    bit to_n;
    int fc_n;
    int sum;
    acc = v && !m_busy;
    edg = (vs == 1'b0) && !m_vs_act;
    m_vs_act = (vs == 1'b0);
    m_upd = 1'b0;
    if (edg) begin
      fc_n = acc ? 0 : ((m_fc < 60) ? m_fc + 1 : 60);
      to_n = (fc_n == 60);
      if (m_pv && !to_n) begin
        m_lvl = m_pl; m_flg = m_pf; m_pv = 1'b0; m_upd = 1'b1;
      end
      if (to_n != m_to) m_upd = 1'b1;
      m_to = to_n;
      m_fc = fc_n;
    end else if (acc) begin
      m_fc = 0;
    end
    if (m_busy) begin
      sum = 0;
      foreach (m_q[i]) sum += m_q[i];
      m_pl = ref_level(sum / 8);
      m_pf = ref_flags(sum / 8);
      m_pv = 1'b1;
      m_q.delete();
      m_busy = 1'b0;
    end
    if (acc) begin
      m_q.push_back(int'(s));
      if (m_q.size() == 8) m_busy = 1'b1;
    end
  endtask

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got {rdy,lvl,dig,upd}=%b required %b at %0t", name, act, exp, $time);
    end
  endtask

  // one clock: drive, let the edge happen, update model, compare #1 later
  task automatic step(input logic v, input logic [7:0] s, input logic vs);
    tif.isample_valid = v;
    tif.isample       = s;
    ivsync            = vs;
    @(posedge iclock);
    model_update(v, s, vs);
    #1;
    check("model", {tif.osample_ready, otemperatura, odig_temp, oframe_update},
          {~m_busy, m_lvl, m_to, m_flg, m_upd});
  endtask

  task automatic do_reset();
    ireset_n = 1'b0;
    tif.isample_valid = 1'b0;
    tif.isample = 8'd0;
    ivsync = 1'b1;
    repeat (2) @(posedge iclock);
    #1;
    check("reset", {tif.osample_ready, otemperatura, odig_temp, oframe_update}, 10'b1_0000_0000_0);
    model_reset();
    ireset_n = 1'b1;
    repeat (3) step(1'b0, 8'd0, 1'b1);
  endtask

  task automatic feed_block(input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < 8; i++) step(1'b1, (i % 2 == 0) ? a : b, 1'b1);
    step(1'b0, 8'd0, 1'b1);
  endtask

  // vsync pulse starting with the frame edge; outputs sampled right after the edge
  task automatic pulse_edge();
    step(1'b0, 8'd0, 1'b0);
  endtask

  task automatic pulse_tail();
    step(1'b0, 8'd0, 1'b0);
    step(1'b0, 8'd0, 1'b0);
    step(1'b0, 8'd0, 1'b1);
    step(1'b0, 8'd0, 1'b1);
  endtask

  typedef struct packed {
    logic [7:0] s0;
    logic [7:0] s1;
    logic [3:0] lvl;
    logic [3:0] dig;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [3:0] prev_lvl;
    logic [3:0] prev_dig;
    logic       v;
    logic [7:0] s;
    int         busy_seen;

    tbl[0] = '{8'd30,  8'd30,  4'd7,  4'b0010};
    tbl[1] = '{8'd10,  8'd10,  4'd0,  4'b0001};
    tbl[2] = '{8'd200, 8'd200, 4'd15, 4'b0100};
    tbl[3] = '{8'd29,  8'd30,  4'd6,  4'b0010};
    tbl[4] = '{8'd16,  8'd17,  4'd0,  4'b0010};
    tbl[5] = '{8'd15,  8'd15,  4'd0,  4'b0001};
    tbl[6] = '{8'd40,  8'd40,  4'd12, 4'b0100};
    tbl[7] = '{8'd39,  8'd39,  4'd11, 4'b0010};
    tbl[8] = '{8'd47,  8'd48,  4'd15, 4'b0100};
    tbl[9] = '{8'd255, 8'd255, 4'd15, 4'b0100};

    do_reset();

    // table: each block is shown only after the following frame edge
    prev_lvl = 4'd0;
    prev_dig = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      feed_block(tbl[k].s0, tbl[k].s1);
      check("hold_before_edge", {1'b1, otemperatura, odig_temp, oframe_update},
            {1'b1, prev_lvl, prev_dig, 1'b0});
      pulse_edge();
      check("table", {1'b1, otemperatura, odig_temp, oframe_update},
            {1'b1, tbl[k].lvl, tbl[k].dig, 1'b1});
      pulse_tail();
      prev_lvl = tbl[k].lvl;
      prev_dig = tbl[k].dig;
    end

    // valid held high: ready drops once per eight accepts
    busy_seen = 0;
    for (int i = 0; i < 27; i++) begin
      step(1'b1, 8'(20 + i), 1'b1);
      if (!tif.osample_ready) busy_seen++;
    end
    check("ready_gaps", 10'(busy_seen), 10'd3);
    step(1'b0, 8'd0, 1'b1);
    pulse_edge();
    pulse_tail();

    // commit in the same cycle as the frame edge: old value stays this frame
    for (int i = 0; i < 8; i++) step(1'b1, 8'd30, 1'b1);
    prev_lvl = otemperatura;
    prev_dig = odig_temp;
    pulse_edge();
    check("commit_at_edge", {1'b1, otemperatura, odig_temp, oframe_update},
          {1'b1, prev_lvl, prev_dig, 1'b0});
    pulse_tail();
    pulse_edge();
    check("commit_next_edge", {1'b1, otemperatura, odig_temp, oframe_update},
          {1'b1, 4'd7, 4'b0010, 1'b1});
    pulse_tail();

    // timeout after 60 sample-free frames, cleared by one sample
    step(1'b1, 8'd20, 1'b1);
    for (int f = 1; f <= 60; f++) begin
      pulse_edge();
      if (f == 59)
        check("timeout_59", {1'b1, otemperatura, odig_temp, oframe_update},
              {1'b1, 4'd7, 4'b0010, 1'b0});
      if (f == 60)
        check("timeout_60", {1'b1, otemperatura, odig_temp, oframe_update},
              {1'b1, 4'd7, 4'b1010, 1'b1});
      pulse_tail();
    end
    step(1'b1, 8'd20, 1'b1);
    pulse_edge();
    check("timeout_clear", {1'b1, otemperatura, odig_temp, oframe_update},
          {1'b1, 4'd7, 4'b0010, 1'b1});
    pulse_tail();

    // reset mid-average discards the partial block
    for (int i = 0; i < 5; i++) step(1'b1, 8'd100, 1'b1);
    do_reset();
    feed_block(8'd30, 8'd30);
    pulse_edge();
    check("after_mid_reset", {1'b1, otemperatura, odig_temp, oframe_update},
          {1'b1, 4'd7, 4'b0010, 1'b1});
    pulse_tail();

    // randomized traffic against the model
    v = 1'b0;
    s = 8'd0;
    for (int c = 0; c < 3000; c++) begin
      if (!(v && m_busy)) begin
        v = ($urandom_range(0, 9) < 7);
        s = 8'($urandom_range(0, 80));
      end
      step(v, s, ((c % 40) < 3) ? 1'b0 : 1'b1);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
